// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the access-size helper for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStore,
        StDone
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes; illegal codes fall through to 4 and are rejected separately.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side strobes of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    modport master (
        output req_valid, req_write, funct3, addr, wdata, mem_data_out,
        input  busy, done, err, rdata, mem_read, mem_write, mem_address, mem_data_in
    );

    modport slave (
        input  req_valid, req_write, funct3, addr, wdata, mem_data_out,
        output busy, done, err, rdata, mem_read, mem_write, mem_address, mem_data_in
    );

endinterface

// File: rtl/Memory.sv
// Byte-array memory: one byte written per clock, four big-endian bytes read combinationally.
module Memory #(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0] r_mem [MEM_BYTES];
    logic       w_unused;

    assign w_unused = ^data_in[31:8];

    always_ff @(posedge clk) begin
        if (mem_write && (address < MEM_BYTES)) begin
            r_mem[address[AW-1:0]] <= data_in[7:0];
        end
    end

    // Bytes past the end of the array read as zero.
    always_comb begin
        data_out = '0;
        if (mem_read) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (({1'b0, address} + 33'(k)) < 33'(MEM_BYTES)) begin
                    data_out[31-8*k -: 8] = r_mem[AW'(address + 32'(k))];
                end
            end
        end
    end

endmodule

// File: rtl/load_extend.sv
// Picks the loaded byte/half/word from a big-endian 4-byte read and extends it to 32 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_B:    o_data = {{24{i_data[31]}}, i_data[31:24]};
            F3_BU:   o_data = {24'b0, i_data[31:24]};
            F3_H:    o_data = {{16{i_data[31]}}, i_data[31:16]};
            F3_HU:   o_data = {16'b0, i_data[31:16]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one RV32I load or store onto the byte-wide Memory block; stores go out
// one byte per cycle, most significant byte of the stored value first.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    lsu_state_e  r_state;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_idx;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;

    logic [2:0]  w_req_size;
    logic [32:0] w_req_last;
    logic        w_req_range;
    logic        w_req_illegal;
    logic [7:0]  w_req_byte;
    logic [2:0]  w_size;
    logic [2:0]  w_next_sel;
    logic [7:0]  w_next_byte;
    logic        w_store_last;
    logic [31:0] w_load_val;

    assign w_req_size  = size_of(bus.funct3);
    // 33-bit end address so a request near 2^32 cannot wrap into range.
    assign w_req_last  = {1'b0, bus.addr} + 33'(w_req_size) - 33'd1;
    assign w_req_range = w_req_last >= 33'(MEM_BYTES);
    assign w_req_illegal = bus.req_write ? !(bus.funct3 inside {F3_B, F3_H, F3_W})
                                         : (bus.funct3 inside {3'b011, 3'b110, 3'b111});
    assign w_req_byte  = 8'(bus.wdata >> {w_req_size - 3'd1, 3'b000});

    assign w_size       = size_of(r_funct3);
    assign w_next_sel   = w_size - 3'd2 - {1'b0, r_idx};
    assign w_next_byte  = 8'(r_wdata >> {w_next_sel, 3'b000});
    assign w_store_last = ({1'b0, r_idx} == (w_size - 3'd1));

    load_extend u_load_extend (
        .i_funct3 (r_funct3),
        .i_data   (bus.mem_data_out),
        .o_data   (w_load_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_base        <= '0;
            r_wdata       <= '0;
            r_funct3      <= '0;
            r_idx         <= '0;
            r_rdata       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_base   <= bus.addr;
                        r_wdata  <= bus.wdata;
                        r_funct3 <= bus.funct3;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        if (w_req_illegal || w_req_range) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.req_write) begin
                            r_state       <= StStore;
                            r_mem_write   <= 1'b1;
                            r_mem_address <= bus.addr;
                            r_mem_data_in <= {24'b0, w_req_byte};
                        end else begin
                            r_state       <= StLoad;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= bus.addr;
                        end
                    end
                end
                StLoad: begin
                    r_rdata <= w_load_val;
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end
                StStore: begin
                    if (w_store_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx         <= r_idx + 2'd1;
                        r_mem_write   <= 1'b1;
                        r_mem_address <= r_base + {30'b0, r_idx} + 32'd1;
                        r_mem_data_in <= {24'b0, w_next_byte};
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.rdata       = r_rdata;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data_in = r_mem_data_in;

endmodule
